// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper
//   Player-input front end for arcade cores. PS/2 key events pass through a
//   runtime-loadable keymap and are merged with the per-player joystick words.
//   Opposing directions are resolved per pair (SOCD), and coin pulses are
//   stretched, optionally triggered by a start press.
//
// Ports
//   clk_sys    system clock
//   reset      synchronous, active-high reset
//   ps2_key    {toggle, pressed, ext, code[7:0]}; a toggle change is an event
//   joy_in     PLAYERS x 16: [3:0]=R,L,D,U, [4+:BUTTONS]=buttons, 12=start, 13=coin
//   socd_mode  0/3 pass, 1 neutral, 2 last-wins
//   map_wr     keymap write strobe
//   map_addr   keymap slot index
//   map_data   {valid, ext_dc, code[8:0]}
//   ctl_n      active-low controls, PS bits per player
//   test_n     active-low service/test (last slot, keyboard only)
module arcade_input_mapper #(
  parameter int          PLAYERS    = 2,
  parameter int          BUTTONS    = 4,
  parameter logic [15:0] COIN_PULSE = 16'd50000,
  parameter int          AUTO_COIN  = 1,
  localparam int         PS         = 6 + BUTTONS,
  localparam int         SLOTS      = PLAYERS * PS + 1,
  localparam int         AW         = $clog2(SLOTS)
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic [10:0]             ps2_key,
  input  logic [PLAYERS*16-1:0]   joy_in,
  input  logic [1:0]              socd_mode,
  input  logic                    map_wr,
  input  logic [AW-1:0]           map_addr,
  input  logic [10:0]             map_data,
  output logic [PLAYERS*PS-1:0]   ctl_n,
  output logic                    test_n
);

  localparam bit       LP_AUTO   = (AUTO_COIN != 0);
  localparam logic [1:0] LAST_NONE = 2'd0;
  localparam logic [1:0] LAST_A    = 2'd1;  // R or D (lower bit of the pair)
  localparam logic [1:0] LAST_B    = 2'd2;  // L or U (upper bit of the pair)

  // Slot b of a player -> bit in that player's joystick word.
  function automatic int joy_bit(input int b);
    if (b < 4 + BUTTONS) return b;
    else if (b == 4 + BUTTONS) return 12;
    else return 13;
  endfunction

  logic               r_toggle_prev;
  logic [SLOTS-1:0]   r_map_valid;
  logic [SLOTS-1:0]   r_map_ext_dc;
  logic [8:0]         r_map_code [SLOTS];
  logic [SLOTS-1:0]   r_key;

  logic [PLAYERS*4-1:0] r_dir_prev;
  logic [1:0]           r_last      [PLAYERS*2];
  logic [1:0]           w_last_next [PLAYERS*2];

  logic [PLAYERS-1:0] r_coin_src_prev;
  logic [PLAYERS-1:0] w_coin_src;
  logic [15:0]        r_coin_cnt  [PLAYERS];
  logic [15:0]        w_cnt_next  [PLAYERS];

  logic                  w_event;
  logic [SLOTS-1:0]      w_match;
  logic [SLOTS-1:0]      w_raw;
  logic [PLAYERS*PS-1:0] w_ctl;
  logic                  w_unused_joy;

  // Joystick bits 14/15 and any spare button bits are intentionally ignored.
  assign w_unused_joy = ^joy_in;

  assign w_event = ps2_key[10] != r_toggle_prev;

  always_comb begin
    w_match = '0;
    for (int s = 0; s < SLOTS; s++) begin
      w_match[s] = r_map_valid[s]
                   && (r_map_code[s][7:0] == ps2_key[7:0])
                   && (r_map_ext_dc[s] || (r_map_code[s][8] == ps2_key[8]));
    end
  end

  // Keymap contents carry no reset; only the valid bits matter after reset.
  always_ff @(posedge clk_sys) begin
    for (int s = 0; s < SLOTS; s++) begin
      if (map_wr && (map_addr == AW'(s))) begin
        r_map_ext_dc[s] <= map_data[9];
        r_map_code[s]   <= map_data[8:0];
      end
    end
  end

  // Toggle history follows ps2_key even in reset so that leaving reset
  // never looks like a key event.
  always_ff @(posedge clk_sys) begin
    r_toggle_prev <= ps2_key[10];
    if (reset) begin
      r_map_valid <= '0;
      r_key       <= '0;
    end else begin
      for (int s = 0; s < SLOTS; s++) begin
        if (map_wr && (map_addr == AW'(s))) begin
          r_map_valid[s] <= map_data[10];
          r_key[s]       <= 1'b0;
        end else if (w_event && w_match[s]) begin
          r_key[s] <= ps2_key[9];
        end
      end
    end
  end

  always_comb begin
    w_raw = r_key;
    for (int p = 0; p < PLAYERS; p++) begin
      for (int b = 0; b < PS; b++) begin
        w_raw[p*PS+b] = r_key[p*PS+b] | joy_in[p*16+joy_bit(b)];
      end
    end
  end

  always_comb begin
    int  ia, ib, ip;
    logic ra, rb;
    int  sc, ss;
    w_ctl = w_raw[PLAYERS*PS-1:0];
    w_coin_src = '0;
    for (int i = 0; i < PLAYERS*2; i++) w_last_next[i] = r_last[i];
    for (int p = 0; p < PLAYERS; p++) w_cnt_next[p] = r_coin_cnt[p];

    for (int p = 0; p < PLAYERS; p++) begin
      for (int k = 0; k < 2; k++) begin
        ia = p*PS + 2*k;
        ib = ia + 1;
        ip = p*2 + k;
        ra = w_raw[ia] & ~r_dir_prev[p*4+2*k];
        rb = w_raw[ib] & ~r_dir_prev[p*4+2*k+1];
        // The current cycle's rise is folded in so last-wins has the same
        // one-edge latency as the plain joystick path.
        if (ra && rb)  w_last_next[ip] = LAST_NONE;
        else if (ra)   w_last_next[ip] = LAST_A;
        else if (rb)   w_last_next[ip] = LAST_B;

        if (w_raw[ia] && w_raw[ib]) begin
          if (socd_mode == 2'd1) begin
            w_ctl[ia] = 1'b0;
            w_ctl[ib] = 1'b0;
          end else if (socd_mode == 2'd2) begin
            w_ctl[ia] = (w_last_next[ip] == LAST_A);
            w_ctl[ib] = (w_last_next[ip] == LAST_B);
          end
        end
      end

      sc = p*PS + 5 + BUTTONS;
      ss = sc - 1;
      w_coin_src[p] = w_raw[sc] | (LP_AUTO & w_raw[ss]);
      if (w_coin_src[p] && !r_coin_src_prev[p])
        w_cnt_next[p] = COIN_PULSE;
      else if (r_coin_cnt[p] != 16'd0)
        w_cnt_next[p] = r_coin_cnt[p] - 16'd1;
      // Driving from the next count makes a one-cycle trigger hold the
      // output low for exactly COIN_PULSE cycles.
      w_ctl[sc] = (w_cnt_next[p] != 16'd0) | w_raw[sc];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ctl_n           <= '1;
      test_n          <= 1'b1;
      r_dir_prev      <= '0;
      r_coin_src_prev <= '0;
      for (int i = 0; i < PLAYERS*2; i++) r_last[i] <= LAST_NONE;
      for (int p = 0; p < PLAYERS; p++) r_coin_cnt[p] <= 16'd0;
    end else begin
      ctl_n           <= ~w_ctl;
      test_n          <= ~r_key[SLOTS-1];
      r_coin_src_prev <= w_coin_src;
      for (int i = 0; i < PLAYERS*2; i++) r_last[i] <= w_last_next[i];
      for (int p = 0; p < PLAYERS; p++) begin
        r_coin_cnt[p] <= w_cnt_next[p];
        for (int j = 0; j < 4; j++) r_dir_prev[p*4+j] <= w_raw[p*PS+j];
      end
    end
  end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed testbench for arcade_input_mapper with PLAYERS=2, BUTTONS=4,
// COIN_PULSE=8, AUTO_COIN=1 (PS=10, SLOTS=21, AW=5).
// P1 ctl_n bits: 0 R, 1 L, 2 D, 3 U, 4..7 buttons, 8 start, 9 coin; P2 = +10.
module tb_arcade_input_mapper;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [31:0] joy_in;
  logic [1:0]  socd_mode;
  logic        map_wr;
  logic [4:0]  map_addr;
  logic [10:0] map_data;
  logic [19:0] ctl_n;
  logic        test_n;

  int n_checks = 0;
  int n_fail   = 0;
  logic tog = 1'b0;

  localparam logic [19:0] ALL1 = 20'hFFFFF;

  arcade_input_mapper #(
    .PLAYERS(2), .BUTTONS(4), .COIN_PULSE(16'd8), .AUTO_COIN(1)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .joy_in(joy_in),
    .socd_mode(socd_mode), .map_wr(map_wr), .map_addr(map_addr),
    .map_data(map_data), .ctl_n(ctl_n), .test_n(test_n)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send_key(input logic pressed, input logic ext, input logic [7:0] code);
    tog = ~tog;
    ps2_key = {tog, pressed, ext, code};
  endtask

  task automatic write_map(input logic [4:0] addr, input logic [10:0] data);
    map_wr = 1'b1; map_addr = addr; map_data = data;
    tick();
    map_wr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    n_checks++;
    if (ctl_n !== ALL1) begin n_fail++; $display("FAIL reset_ctl_n: got %h expected %h", ctl_n, ALL1); end
    n_checks++;
    if (test_n !== 1'b1) begin n_fail++; $display("FAIL reset_test_n: got %b expected 1", test_n); end
  endtask

  task automatic test_keymap();
    write_map(5'd0, {1'b1, 1'b1, 9'h074});
    send_key(1'b1, 1'b1, 8'h74);
    tick();
    n_checks++;
    if (ctl_n !== ALL1) begin n_fail++; $display("FAIL key_latency_1: got %h expected %h", ctl_n, ALL1); end
    tick();
    n_checks++;
    if (ctl_n !== 20'hFFFFE) begin n_fail++; $display("FAIL key_press: got %h expected %h", ctl_n, 20'hFFFFE); end
    send_key(1'b0, 1'b1, 8'h74);
    tick(); tick();
    n_checks++;
    if (ctl_n !== ALL1) begin n_fail++; $display("FAIL key_release: got %h expected %h", ctl_n, ALL1); end
    write_map(5'd0, {1'b1, 1'b0, 9'h074});
    send_key(1'b1, 1'b1, 8'h74);
    tick(); tick();
    n_checks++;
    if (ctl_n !== ALL1) begin n_fail++; $display("FAIL key_ext_mismatch: got %h expected %h", ctl_n, ALL1); end
    send_key(1'b1, 1'b0, 8'h74);
    tick(); tick();
    n_checks++;
    if (ctl_n !== 20'hFFFFE) begin n_fail++; $display("FAIL key_ext_match: got %h expected %h", ctl_n, 20'hFFFFE); end
    send_key(1'b0, 1'b0, 8'h74);
    tick(); tick();
    // Write and matching event on the same slot in one cycle: write wins.
    write_map(5'd0, {1'b1, 1'b1, 9'h074});
    map_wr = 1'b1; map_addr = 5'd0; map_data = {1'b1, 1'b1, 9'h074};
    send_key(1'b1, 1'b1, 8'h74);
    tick();
    map_wr = 1'b0;
    tick();
    n_checks++;
    if (ctl_n[0] !== 1'b1) begin n_fail++; $display("FAIL wr_beats_event: got %b expected 1", ctl_n[0]); end
    write_map(5'd20, {1'b1, 1'b1, 9'h007});
    send_key(1'b1, 1'b0, 8'h07);
    tick(); tick();
    n_checks++;
    if (test_n !== 1'b0 || ctl_n !== ALL1) begin n_fail++; $display("FAIL test_key: got test_n=%b ctl_n=%h expected 0 %h", test_n, ctl_n, ALL1); end
    send_key(1'b0, 1'b0, 8'h07);
    tick(); tick();
    n_checks++;
    if (test_n !== 1'b1) begin n_fail++; $display("FAIL test_key_release: got %b expected 1", test_n); end
  endtask

  task automatic test_multi_match();
    write_map(5'd4,  {1'b1, 1'b1, 9'h014});
    write_map(5'd14, {1'b1, 1'b1, 9'h014});
    send_key(1'b1, 1'b0, 8'h14);
    tick(); tick();
    n_checks++;
    if (ctl_n !== 20'hFBFEF) begin n_fail++; $display("FAIL multi_match: got %h expected %h", ctl_n, 20'hFBFEF); end
    send_key(1'b0, 1'b0, 8'h14);
    tick(); tick();
    n_checks++;
    if (ctl_n !== ALL1) begin n_fail++; $display("FAIL multi_release: got %h expected %h", ctl_n, ALL1); end
    write_map(5'd21, {1'b1, 1'b1, 9'h055});
    send_key(1'b1, 1'b0, 8'h55);
    tick(); tick();
    n_checks++;
    if (ctl_n !== ALL1 || test_n !== 1'b1) begin n_fail++; $display("FAIL unmapped_ignored: got %h/%b expected %h/1", ctl_n, test_n, ALL1); end
    send_key(1'b0, 1'b0, 8'h55);
    tick();
  endtask

  task automatic test_socd();
    socd_mode = 2'd0;
    joy_in = 32'h3;
    tick();
    n_checks++;
    if (ctl_n[1:0] !== 2'b00) begin n_fail++; $display("FAIL socd_pass: got %b expected 00", ctl_n[1:0]); end
    socd_mode = 2'd1;
    joy_in = 32'h000C_0003;
    tick();
    n_checks++;
    if (ctl_n[1:0] !== 2'b11 || ctl_n[13:12] !== 2'b11) begin n_fail++; $display("FAIL socd_neutral: got %b %b expected 11 11", ctl_n[1:0], ctl_n[13:12]); end
    joy_in = 32'h0;
    tick();
    socd_mode = 2'd2;
    joy_in = 32'h2;
    tick();
    n_checks++;
    if (ctl_n[1:0] !== 2'b01) begin n_fail++; $display("FAIL socd_lw_left: got %b expected 01", ctl_n[1:0]); end
    repeat (4) tick();
    joy_in = 32'h3;
    tick();
    n_checks++;
    if (ctl_n[1:0] !== 2'b10) begin n_fail++; $display("FAIL socd_lw_right_wins: got %b expected 10", ctl_n[1:0]); end
    joy_in = 32'h2;
    tick();
    n_checks++;
    if (ctl_n[1:0] !== 2'b01) begin n_fail++; $display("FAIL socd_lw_back_left: got %b expected 01", ctl_n[1:0]); end
    joy_in = 32'h0;
    tick();
    joy_in = 32'h3;
    tick();
    n_checks++;
    if (ctl_n[1:0] !== 2'b11) begin n_fail++; $display("FAIL socd_lw_simul: got %b expected 11", ctl_n[1:0]); end
    joy_in = 32'h1;
    tick();
    n_checks++;
    if (ctl_n[1:0] !== 2'b10) begin n_fail++; $display("FAIL socd_lw_simul_release: got %b expected 10", ctl_n[1:0]); end
    joy_in = 32'h0;
    socd_mode = 2'd0;
    tick(); tick();
  endtask

  task automatic test_coin();
    int lows;
    int last_low;
    joy_in = 32'h0;
    joy_in[13] = 1'b1;
    lows = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      joy_in[13] = 1'b0;
      if (ctl_n[9] === 1'b0) lows++;
    end
    n_checks++;
    if (lows !== 8) begin n_fail++; $display("FAIL coin_single: got %0d low cycles expected 8", lows); end

    joy_in[13] = 1'b1;
    lows = 0;
    last_low = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      joy_in[13] = (i == 5);
      if (ctl_n[9] === 1'b0) begin lows++; last_low = i; end
    end
    n_checks++;
    if (lows !== 14 || last_low !== 13) begin n_fail++; $display("FAIL coin_retrigger: got %0d lows ending %0d expected 14 ending 13", lows, last_low); end

    joy_in = 32'h0;
    joy_in[12] = 1'b1;
    tick();
    n_checks++;
    if (ctl_n[9:8] !== 2'b00) begin n_fail++; $display("FAIL auto_coin_start: got %b expected 00", ctl_n[9:8]); end
    lows = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ctl_n[9] === 1'b0) lows++;
    end
    n_checks++;
    if (lows !== 8 || ctl_n[8] !== 1'b0) begin n_fail++; $display("FAIL auto_coin_pulse: got %0d lows start=%b expected 8 start=0", lows, ctl_n[8]); end
    joy_in = 32'h0;
    tick();
  endtask

  task automatic test_reset_mid();
    write_map(5'd0, {1'b1, 1'b1, 9'h074});
    send_key(1'b1, 1'b1, 8'h74);
    tick(); tick();
    joy_in[13] = 1'b1;
    tick();
    joy_in[13] = 1'b0;
    tick();
    n_checks++;
    if (ctl_n[0] !== 1'b0 || ctl_n[9] !== 1'b0) begin n_fail++; $display("FAIL pre_reset_active: got %b%b expected 00", ctl_n[9], ctl_n[0]); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (ctl_n !== ALL1 || test_n !== 1'b1) begin n_fail++; $display("FAIL mid_reset: got %h/%b expected %h/1", ctl_n, test_n, ALL1); end
    tick();
    n_checks++;
    if (ctl_n !== ALL1) begin n_fail++; $display("FAIL post_reset_coin_cleared: got %h expected %h", ctl_n, ALL1); end
    send_key(1'b0, 1'b1, 8'h74);
    tick(); tick();
    send_key(1'b1, 1'b1, 8'h74);
    tick(); tick();
    n_checks++;
    if (ctl_n !== ALL1) begin n_fail++; $display("FAIL post_reset_unmapped: got %h expected %h", ctl_n, ALL1); end
    write_map(5'd0, {1'b1, 1'b1, 9'h074});
    send_key(1'b1, 1'b1, 8'h74);
    tick(); tick();
    n_checks++;
    if (ctl_n !== 20'hFFFFE) begin n_fail++; $display("FAIL post_reset_remap: got %h expected %h", ctl_n, 20'hFFFFE); end
  endtask

  initial begin
    reset = 1'b1;
    ps2_key = 11'h0;
    joy_in = 32'h0;
    socd_mode = 2'd0;
    map_wr = 1'b0;
    map_addr = 5'd0;
    map_data = 11'h0;
    test_reset();
    test_keymap();
    test_multi_match();
    test_socd();
    test_coin();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
